// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
//   Parametrised N:1 streaming multiplexer with a round-robin arbiter and a
//   single registered output stage (1-cycle latency, 1 word/cycle throughput).
//
// Parameters
//   NUM_CH  number of input channels (>=2, any value, not only powers of 2)
//   DATA_W  data width per channel
//   CH_W    channel index width, $clog2(NUM_CH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous assert, active-low reset
//   in_valid   per-channel valid
//   in_data    packed channel data; channel k = in_data[k*DATA_W +: DATA_W]
//   in_ready   per-channel ready, one-hot or zero
//   out_valid  output register holds a word
//   out_data   registered output word
//   out_ch     channel index out_data came from
//   out_ready  consumer accepts the output word
//   sel_en     (MUX_SEL_OVERRIDE_EN only) restrict eligibility to channel sel
//   sel        (MUX_SEL_OVERRIDE_EN only) forced channel index
//
// Build option
//   MUX_SEL_OVERRIDE_EN  adds sel_en/sel fixed-select override ports.
// ---------------------------------------------------------------------------
module stream_mux_rr #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
`ifdef MUX_SEL_OVERRIDE_EN
  input  logic                     sel_en,
  input  logic [CH_W-1:0]          sel,
`endif
  input  logic                     out_ready
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   r_ptr;

  logic [NUM_CH-1:0] w_elig;
  logic              w_load;
  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt;
  logic [DATA_W-1:0] w_gnt_data;
  logic [CH_W-1:0]   w_ptr_nxt;
  int unsigned       w_idx;

  // Eligibility: every valid channel, or only channel sel under override.
  // An out-of-range sel matches no channel, so nothing is granted.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef MUX_SEL_OVERRIDE_EN
      w_elig[i] = in_valid[i] & (!sel_en | (sel == CH_W'(i)));
`else
      w_elig[i] = in_valid[i];
`endif
    end
  end

  // Round-robin scan starting at r_ptr, wrapping modulo NUM_CH explicitly so
  // non-power-of-2 channel counts wrap correctly.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (!w_gnt_vld && w_elig[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = CH_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_gnt == CH_W'(i)) w_gnt_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_ptr_nxt = (w_gnt == CH_W'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;

  // rst_n gates the combinational ready so no handshake appears while reset
  // is held, even though the output register is empty.
  assign w_load = rst_n & (!r_out_valid | out_ready);

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      in_ready[i] = w_load & w_gnt_vld & (w_gnt == CH_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_gnt_vld) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_ch    <= w_gnt;
        r_ptr       <= w_ptr_nxt;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule
